// File: rtl/exposure_ctrl.sv
// Camera sequencing controller: exposure timer handshake and two-row readout.
// Owns the exposure time register and drives the pixel array / ADC strobes.
module exposure_ctrl #(
    parameter int EX_DEFAULT = 5,
    parameter int EX_MIN     = 2,
    parameter int EX_MAX     = 30,
    parameter int MAX_WAIT   = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic       exp_increase,
    input  logic       exp_decrease,
    input  logic       ovf5,
    output logic       start,
    output logic [4:0] ex_time,
    output logic       erase,
    output logic       expose,
    output logic       nre_1,
    output logic       nre_2,
    output logic       adc,
    output logic       timeout
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        EXPOSE,
        RD1_SEL,
        RD1_ADC,
        RD2_SEL,
        RD2_ADC
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;

    logic inc_req;
    logic dec_req;

    assign inc_req = exp_increase & ~exp_decrease;
    assign dec_req = exp_decrease & ~exp_increase;

    // Outputs are loaded on the transition so they match the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ex_time  <= 5'(EX_DEFAULT);
            wait_cnt <= '0;
            start    <= 1'b0;
            erase    <= 1'b1;
            expose   <= 1'b0;
            nre_1    <= 1'b1;
            nre_2    <= 1'b1;
            adc      <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            start <= 1'b0;
            adc   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (init) begin
                        state    <= START;
                        timeout  <= 1'b0;
                        start    <= 1'b1;
                        erase    <= 1'b0;
                        expose   <= 1'b1;
                        wait_cnt <= '0;
                    end else if (inc_req && ex_time < 5'(EX_MAX)) begin
                        ex_time <= ex_time + 5'd1;
                    end else if (dec_req && ex_time > 5'(EX_MIN)) begin
                        ex_time <= ex_time - 5'd1;
                    end
                end
                START: begin
                    state    <= EXPOSE;
                    wait_cnt <= '0;
                end
                EXPOSE: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // First EXPOSE cycle may still see a stale ovf5 from the timer.
                    if (wait_cnt != '0 && ovf5) begin
                        state  <= RD1_SEL;
                        expose <= 1'b0;
                        nre_1  <= 1'b0;
                    end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
                        state   <= RD1_SEL;
                        expose  <= 1'b0;
                        nre_1   <= 1'b0;
                        timeout <= 1'b1;
                    end
                end
                RD1_SEL: begin
                    state <= RD1_ADC;
                    adc   <= 1'b1;
                end
                RD1_ADC: begin
                    state <= RD2_SEL;
                    nre_1 <= 1'b1;
                    nre_2 <= 1'b0;
                end
                RD2_SEL: begin
                    state <= RD2_ADC;
                    adc   <= 1'b1;
                end
                RD2_ADC: begin
                    state <= IDLE;
                    nre_2 <= 1'b1;
                    erase <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    erase  <= 1'b1;
                    expose <= 1'b0;
                    nre_1  <= 1'b1;
                    nre_2  <= 1'b1;
                end
            endcase
        end
    end

endmodule
